// File: rtl/id_stage_if.sv
// Bundle of fetch-side, execute-side and output-side signals of the decode stage.
// master = the surrounding pipeline / bench, slave = id_stage.
interface id_stage_if #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_instruction;
  logic [31:0]            in_pc;
  logic                   flush;
  logic                   ex_mem_read;
  logic [REG_ADDR_W-1:0]  ex_rd;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_pc;
  logic [2:0]             out_funct3;
  logic [6:0]             out_funct7;
  logic [REG_ADDR_W-1:0]  out_rs1;
  logic [REG_ADDR_W-1:0]  out_rs2;
  logic [REG_ADDR_W-1:0]  out_rd;
  logic [31:0]            out_imm;
  logic                   out_op1_src;
  logic                   out_op2_src;
  logic                   out_mem_read;
  logic                   out_mem_write;
  logic                   out_reg_write;
  logic                   out_illegal;
  logic [1:0]             out_wb_src;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output in_valid, in_instruction, in_pc, flush, ex_mem_read, ex_rd, out_ready,
    input  in_ready, out_valid, out_pc, out_funct3, out_funct7, out_rs1, out_rs2,
           out_rd, out_imm, out_op1_src, out_op2_src, out_mem_read, out_mem_write,
           out_reg_write, out_illegal, out_wb_src, stall_count
  );

  modport slave (
    input  in_valid, in_instruction, in_pc, flush, ex_mem_read, ex_rd, out_ready,
    output in_ready, out_valid, out_pc, out_funct3, out_funct7, out_rs1, out_rs2,
           out_rd, out_imm, out_op1_src, out_op2_src, out_mem_read, out_mem_write,
           out_reg_write, out_illegal, out_wb_src, stall_count
  );
endinterface

// File: rtl/id_stage.sv
// RV32I/E instruction decode stage: combinational decode, one output register, load-use stall.
// Optional macro ID_RV32M_EN accepts the M-extension R-type encoding (funct7 = 0000001).
module id_stage #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  id_stage_if.slave bus
);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_L     = 7'b0000011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;

  typedef struct packed {
    logic [31:0]           pc;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [31:0]           imm;
    logic                  op1_src;
    logic                  op2_src;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  illegal;
    logic [1:0]            wb_src;
  } dec_t;

  logic [31:0]           w_instr;
  logic [6:0]            w_opcode;
  logic                  w_is_r, w_is_i, w_is_l, w_is_jalr, w_is_s;
  logic                  w_is_b, w_is_lui, w_is_auipc, w_is_jal;
  logic                  w_known, w_writes_rd, w_reads_rs1, w_reads_rs2;
  logic [REG_ADDR_W-1:0] w_rs1_idx, w_rs2_idx, w_rd_idx;
  logic                  w_rs1_oob, w_rs2_oob, w_rd_oob;
  logic                  w_f7_ok;
  logic                  w_illegal;
  logic [31:0]           w_imm;
  dec_t                  w_dec;
  logic                  w_hazard, w_in_ready, w_accept;

  dec_t                   r_out;
  logic                   r_out_valid;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  assign w_instr  = bus.in_instruction;
  assign w_opcode = w_instr[6:0];

  assign w_is_r     = (w_opcode == OPC_R);
  assign w_is_i     = (w_opcode == OPC_I);
  assign w_is_l     = (w_opcode == OPC_L);
  assign w_is_jalr  = (w_opcode == OPC_JALR);
  assign w_is_s     = (w_opcode == OPC_S);
  assign w_is_b     = (w_opcode == OPC_B);
  assign w_is_lui   = (w_opcode == OPC_LUI);
  assign w_is_auipc = (w_opcode == OPC_AUIPC);
  assign w_is_jal   = (w_opcode == OPC_JAL);

  assign w_known     = w_is_r | w_is_i | w_is_l | w_is_jalr | w_is_s | w_is_b |
                       w_is_lui | w_is_auipc | w_is_jal;
  assign w_writes_rd = w_is_r | w_is_i | w_is_l | w_is_jalr | w_is_lui | w_is_auipc | w_is_jal;
  assign w_reads_rs1 = ~(w_is_lui | w_is_auipc | w_is_jal);
  assign w_reads_rs2 = w_is_r | w_is_s | w_is_b;

  assign w_rs1_idx = w_instr[15 +: REG_ADDR_W];
  assign w_rs2_idx = w_instr[20 +: REG_ADDR_W];
  assign w_rd_idx  = w_instr[7  +: REG_ADDR_W];

  // Register fields are always 5 bits wide; RV32E must reject indices 16..31.
  assign w_rs1_oob = (w_instr[19:15] >> REG_ADDR_W) != 5'd0;
  assign w_rs2_oob = (w_instr[24:20] >> REG_ADDR_W) != 5'd0;
  assign w_rd_oob  = (w_instr[11:7]  >> REG_ADDR_W) != 5'd0;

`ifdef ID_RV32M_EN
  assign w_f7_ok = (w_instr[31:25] == 7'b0000000) | (w_instr[31:25] == 7'b0100000) |
                   (w_instr[31:25] == 7'b0000001);
`else
  assign w_f7_ok = (w_instr[31:25] == 7'b0000000) | (w_instr[31:25] == 7'b0100000);
`endif

  assign w_illegal = ~w_known | (w_writes_rd & w_rd_oob) | (w_reads_rs1 & w_rs1_oob) |
                     (w_reads_rs2 & w_rs2_oob) | (w_is_r & ~w_f7_ok);

  always_comb begin
    // NOTE: default first so every path assigns w_imm and no latch is inferred.
    w_imm = '0;
    if (w_is_i | w_is_l | w_is_jalr)
      w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
    else if (w_is_s)
      w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    else if (w_is_b)
      w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    else if (w_is_lui | w_is_auipc)
      w_imm = {w_instr[31:12], 12'h000};
    else if (w_is_jal)
      w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
  end

  always_comb begin
    w_dec           = '0;
    w_dec.pc        = bus.in_pc;
    w_dec.funct3    = w_instr[14:12];
    w_dec.funct7    = w_instr[31:25];
    w_dec.rs1       = w_is_lui ? '0 : w_rs1_idx;
    w_dec.rs2       = w_rs2_idx;
    w_dec.rd        = w_rd_idx;
    w_dec.imm       = w_imm;
    w_dec.op1_src   = w_is_b | w_is_auipc | w_is_jal;
    w_dec.op2_src   = ~w_is_r;
    w_dec.mem_read  = w_is_l & ~w_illegal;
    w_dec.mem_write = w_is_s & ~w_illegal;
    w_dec.reg_write = w_writes_rd & (w_rd_idx != '0) & ~w_illegal;
    w_dec.illegal   = w_illegal;
    w_dec.wb_src    = w_is_l ? 2'd1 : (w_is_jal ? 2'd3 : (w_is_jalr ? 2'd2 : 2'd0));
  end

  // Load-use: the offered instruction needs a register the load in EX has not produced yet.
  assign w_hazard = bus.in_valid & bus.ex_mem_read & (bus.ex_rd != '0) &
                    ((w_reads_rs1 & (w_rs1_idx == bus.ex_rd)) |
                     (w_reads_rs2 & (w_rs2_idx == bus.ex_rd)));

  assign w_in_ready = (~r_out_valid | bus.out_ready) & ~w_hazard & ~bus.flush;
  assign w_accept   = bus.in_valid & w_in_ready;

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      // NOTE: data fields are reset too, so downstream sees all-zero outputs during reset.
      r_out       <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= w_dec;
      r_out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (w_hazard & ~bus.flush & ~(&r_stall_cnt))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_pc        = r_out.pc;
  assign bus.out_funct3    = r_out.funct3;
  assign bus.out_funct7    = r_out.funct7;
  assign bus.out_rs1       = r_out.rs1;
  assign bus.out_rs2       = r_out.rs2;
  assign bus.out_rd        = r_out.rd;
  assign bus.out_imm       = r_out.imm;
  assign bus.out_op1_src   = r_out.op1_src;
  assign bus.out_op2_src   = r_out.op2_src;
  assign bus.out_mem_read  = r_out.mem_read;
  assign bus.out_mem_write = r_out.mem_write;
  assign bus.out_reg_write = r_out.reg_write;
  assign bus.out_illegal   = r_out.illegal;
  assign bus.out_wb_src    = r_out.wb_src;
  assign bus.stall_count   = r_stall_cnt;

endmodule
